load_store_unit: RTL and testbench

Initiator for the word-addressed data memory port. It accepts one load/store request at a time from the pipeline MEM stage. It drives mem_addr/mem_re/mem_we/mem_wdata toward the data memory and returns aligned, extended load data.
- Byte and halfword stores use read-modify-write, because the memory has only a whole-word write enable.
- Misaligned and out-of-range accesses are rejected without touching memory.

---
 rtl/load_store_unit.sv | 202 ++++++++++++++++++++
 tb/tb_load_store_unit.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// load_store_unit: single-outstanding load/store initiator for a word-addressed
// data memory. Byte/halfword stores are done as read-modify-write because the
// memory only has a whole-word write enable. Misaligned, illegal-width and
// out-of-range requests are answered with an error and never touch memory.
// Optional build macro: LSU_STATS_EN adds saturating load/store/error counters.
module load_store_unit #(
  parameter int MEM_WORDS = 64,
  parameter int CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_store,
  input  logic [2:0]       req_funct3,
  input  logic [31:0]      req_addr,
  input  logic [31:0]      req_wdata,
  output logic             resp_valid,
  output logic             resp_err,
  output logic [31:0]      resp_rdata,
  output logic [31:0]      mem_addr,
  output logic             mem_re,
  output logic             mem_we,
  output logic [31:0]      mem_wdata,
  input  logic [31:0]      mem_rdata
`ifdef LSU_STATS_EN
  ,
  output logic [CNT_W-1:0] stat_loads,
  output logic [CNT_W-1:0] stat_stores,
  output logic [CNT_W-1:0] stat_errs
`endif
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LOAD   = 3'd1;
  localparam logic [2:0] S_WRITE  = 3'd2;
  localparam logic [2:0] S_RMW_RD = 3'd3;
  localparam logic [2:0] S_RMW_WR = 3'd4;
  localparam logic [2:0] S_RESP   = 3'd5;

  logic [2:0]  state_q, state_d;
  logic        store_q, store_d;
  logic [2:0]  funct3_q, funct3_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] merge_q, merge_d;
  logic        resp_err_q, resp_err_d;
  logic [31:0] resp_rdata_q, resp_rdata_d;
  logic        req_err;

  // Pull the addressed byte/half out of a memory word and extend it to 32 bits.
  function automatic logic [31:0] extract_lane(input logic [31:0] word,
                                               input logic [2:0]  f3,
                                               input logic [1:0]  off);
    logic [7:0]  b;
    logic [15:0] h;
    b = word[{off, 3'b000} +: 8];
    h = word[{off[1], 4'b0000} +: 16];
    case (f3)
      3'b000:  extract_lane = {{24{b[7]}}, b};
      3'b001:  extract_lane = {{16{h[15]}}, h};
      3'b100:  extract_lane = {24'h0, b};
      3'b101:  extract_lane = {16'h0, h};
      default: extract_lane = word;
    endcase
  endfunction

  // Replace the addressed byte/half of the old word with the new store data.
  function automatic logic [31:0] merge_lane(input logic [31:0] word,
                                             input logic [31:0] wd,
                                             input logic [2:0]  f3,
                                             input logic [1:0]  off);
    merge_lane = word;
    if (f3 == 3'b000) merge_lane[{off, 3'b000} +: 8] = wd[7:0];
    else              merge_lane[{off[1], 4'b0000} +: 16] = wd[15:0];
  endfunction

  // Request legality: width code, store width, alignment and memory range.
  always_comb begin
    req_err = 1'b0;
    if (req_funct3 == 3'b011 || req_funct3 == 3'b110 || req_funct3 == 3'b111) req_err = 1'b1;
    if (req_store && (req_funct3 == 3'b100 || req_funct3 == 3'b101)) req_err = 1'b1;
    if ((req_funct3 == 3'b001 || req_funct3 == 3'b101) && req_addr[0]) req_err = 1'b1;
    if (req_funct3 == 3'b010 && req_addr[1:0] != 2'b00) req_err = 1'b1;
    if ({2'b00, req_addr[31:2]} >= 32'(MEM_WORDS)) req_err = 1'b1;
  end

  // Next-state and datapath register updates for the request FSM.
  always_comb begin
    state_d      = state_q;
    store_d      = store_q;
    funct3_d     = funct3_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    merge_d      = merge_q;
    resp_err_d   = resp_err_q;
    resp_rdata_d = resp_rdata_q;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          store_d      = req_store;
          funct3_d     = req_funct3;
          addr_d       = req_addr;
          wdata_d      = req_wdata;
          resp_err_d   = req_err;
          resp_rdata_d = 32'h0;
          if (req_err)                  state_d = S_RESP;
          else if (!req_store)          state_d = S_LOAD;
          else if (req_funct3 == 3'b010) state_d = S_WRITE;
          else                          state_d = S_RMW_RD;
        end
      end
      S_LOAD: begin
        resp_rdata_d = extract_lane(mem_rdata, funct3_q, addr_q[1:0]);
        state_d      = S_RESP;
      end
      S_WRITE:  state_d = S_RESP;
      S_RMW_RD: begin
        merge_d = merge_lane(mem_rdata, wdata_q, funct3_q, addr_q[1:0]);
        state_d = S_RMW_WR;
      end
      S_RMW_WR: state_d = S_RESP;
      S_RESP:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // State and datapath registers; reset aborts any request in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      store_q      <= 1'b0;
      funct3_q     <= 3'b000;
      addr_q       <= 32'h0;
      wdata_q      <= 32'h0;
      merge_q      <= 32'h0;
      resp_err_q   <= 1'b0;
      resp_rdata_q <= 32'h0;
    end else begin
      state_q      <= state_d;
      store_q      <= store_d;
      funct3_q     <= funct3_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      merge_q      <= merge_d;
      resp_err_q   <= resp_err_d;
      resp_rdata_q <= resp_rdata_d;
    end
  end

  // Memory strobes decode straight from state so reset drops them at once.
  always_comb begin
    req_ready  = (state_q == S_IDLE);
    resp_valid = (state_q == S_RESP);
    resp_err   = resp_err_q;
    resp_rdata = resp_rdata_q;
    mem_addr   = {addr_q[31:2], 2'b00};
    mem_re     = (state_q == S_LOAD) || (state_q == S_RMW_RD);
    mem_we     = (state_q == S_WRITE) || (state_q == S_RMW_WR);
    mem_wdata  = 32'h0;
    if (state_q == S_WRITE)  mem_wdata = wdata_q;
    if (state_q == S_RMW_WR) mem_wdata = merge_q;
  end

`ifdef LSU_STATS_EN
  logic [CNT_W-1:0] loads_q, loads_d, stores_q, stores_d, errs_q, errs_d;

  // Count completions in their RESP cycle, saturating at all-ones.
  always_comb begin
    loads_d  = loads_q;
    stores_d = stores_q;
    errs_d   = errs_q;
    if (state_q == S_RESP) begin
      if (resp_err_q) begin
        if (errs_q != '1) errs_d = errs_q + 1'b1;
      end else if (store_q) begin
        if (stores_q != '1) stores_d = stores_q + 1'b1;
      end else begin
        if (loads_q != '1) loads_d = loads_q + 1'b1;
      end
    end
  end

  // Statistics counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      loads_q  <= '0;
      stores_q <= '0;
      errs_q   <= '0;
    end else begin
      loads_q  <= loads_d;
      stores_q <= stores_d;
      errs_q   <= errs_d;
    end
  end

  assign stat_loads  = loads_q;
  assign stat_stores = stores_q;
  assign stat_errs   = errs_q;
`endif

endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: directed bench for load_store_unit with a behavioural
// 64-word memory preloaded mem[i]=i. Stats checks compile in with LSU_STATS_EN.
module tb_load_store_unit;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_store;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_err;
  logic [31:0] resp_rdata;
  logic [31:0] mem_addr;
  logic        mem_re;
  logic        mem_we;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
`ifdef LSU_STATS_EN
  logic [15:0] stat_loads, stat_stores, stat_errs;
`endif

  logic [31:0] mem [0:63];
  int tests_run = 0;
  int tests_failed = 0;
  int overlap_cnt = 0;
  int exp_loads = 0;
  int exp_stores = 0;
  int exp_errs = 0;

  load_store_unit #(.MEM_WORDS(64), .CNT_W(16)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_store  (req_store),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_err   (resp_err),
    .resp_rdata (resp_rdata),
    .mem_addr   (mem_addr),
    .mem_re     (mem_re),
    .mem_we     (mem_we),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata)
`ifdef LSU_STATS_EN
    ,
    .stat_loads (stat_loads),
    .stat_stores(stat_stores),
    .stat_errs  (stat_errs)
`endif
  );

  // Free-running clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Combinational memory read, guarded against out-of-range indices.
  assign mem_rdata = (mem_addr[31:8] == 24'h0) ? mem[mem_addr[7:2]] : 32'h0;

  // Memory write on the rising edge when the DUT strobes mem_we.
  always @(posedge clk) begin
    if (mem_we && mem_addr[31:8] == 24'h0) mem[mem_addr[7:2]] <= mem_wdata;
  end

  // Watch for read and write strobes colliding in the same cycle.
  always @(negedge clk) begin
    if (mem_re && mem_we) overlap_cnt++;
  end

  // Count one comparison and report it when observed differs from expected.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    tests_run++;
    if (observed !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, observed, expected);
    end
  endtask

  // Issue one request, follow it to its response and check timing and results.
  task automatic applyStimulus(input string tag, input logic st, input logic [2:0] f3,
                               input logic [31:0] addr, input logic [31:0] wd,
                               input int exp_lat, input logic exp_err,
                               input logic [31:0] exp_rdata, input int exp_re,
                               input int exp_we, input logic [31:0] exp_wd);
    int lat, re_n, we_n;
    logic [31:0] wd_seen, rd_seen;
    logic err_seen;
    lat = 0; re_n = 0; we_n = 0;
    wd_seen = 32'h0; rd_seen = 32'h0; err_seen = 1'b0;
    @(negedge clk);
    req_valid  = 1'b1;
    req_store  = st;
    req_funct3 = f3;
    req_addr   = addr;
    req_wdata  = wd;
    @(posedge clk);
    #1 req_valid = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (mem_re) re_n++;
      if (mem_we) begin
        we_n++;
        wd_seen = mem_wdata;
      end
      if (resp_valid) begin
        lat = k;
        err_seen = resp_err;
        rd_seen = resp_rdata;
        break;
      end
    end
    checkOutput({tag, "_latency"}, 32'(lat), 32'(exp_lat));
    checkOutput({tag, "_err"}, {31'h0, err_seen}, {31'h0, exp_err});
    checkOutput({tag, "_rdata"}, rd_seen, exp_rdata);
    checkOutput({tag, "_re_cycles"}, 32'(re_n), 32'(exp_re));
    checkOutput({tag, "_we_cycles"}, 32'(we_n), 32'(exp_we));
    if (exp_we != 0) checkOutput({tag, "_wdata"}, wd_seen, exp_wd);
    @(negedge clk);
    checkOutput({tag, "_resp_one_cycle"}, {31'h0, resp_valid}, 32'h0);
    if (exp_err) exp_errs++;
    else if (st) exp_stores++;
    else exp_loads++;
  endtask

  // Main directed sequence.
  initial begin
    int we_n, resp_n;
    for (int i = 0; i < 64; i++) mem[i] = 32'(i);
    rst_n = 1'b0;
    req_valid = 1'b0;
    req_store = 1'b0;
    req_funct3 = 3'b000;
    req_addr = 32'h0;
    req_wdata = 32'h0;
    #1;
    checkOutput("rst_req_ready", {31'h0, req_ready}, 32'h1);
    checkOutput("rst_resp_valid", {31'h0, resp_valid}, 32'h0);
    checkOutput("rst_resp_err", {31'h0, resp_err}, 32'h0);
    checkOutput("rst_resp_rdata", resp_rdata, 32'h0);
    checkOutput("rst_mem_re", {31'h0, mem_re}, 32'h0);
    checkOutput("rst_mem_we", {31'h0, mem_we}, 32'h0);
    checkOutput("rst_mem_wdata", mem_wdata, 32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Loads and stores: tag, store, funct3, addr, wdata, latency, err, rdata, re, we, wdata
    applyStimulus("lw_10",  1'b0, 3'b010, 32'h10, 32'h0, 2, 1'b0, 32'h00000004, 1, 0, 32'h0);
    applyStimulus("sb_11",  1'b1, 3'b000, 32'h11, 32'h123456AB, 3, 1'b0, 32'h0, 1, 1, 32'h0000AB04);
    checkOutput("mem4_after_sb", mem[4], 32'h0000AB04);
    applyStimulus("lbu_11", 1'b0, 3'b100, 32'h11, 32'h0, 2, 1'b0, 32'h000000AB, 1, 0, 32'h0);
    applyStimulus("lb_11",  1'b0, 3'b000, 32'h11, 32'h0, 2, 1'b0, 32'hFFFFFFAB, 1, 0, 32'h0);
    applyStimulus("sh_1a",  1'b1, 3'b001, 32'h1A, 32'h00008001, 3, 1'b0, 32'h0, 1, 1, 32'h80010006);
    checkOutput("mem6_after_sh", mem[6], 32'h80010006);
    applyStimulus("lh_1a",  1'b0, 3'b001, 32'h1A, 32'h0, 2, 1'b0, 32'hFFFF8001, 1, 0, 32'h0);
    applyStimulus("lhu_1a", 1'b0, 3'b101, 32'h1A, 32'h0, 2, 1'b0, 32'h00008001, 1, 0, 32'h0);
    applyStimulus("sw_1c",  1'b1, 3'b010, 32'h1C, 32'hDEADBEEF, 2, 1'b0, 32'h0, 0, 1, 32'hDEADBEEF);
    applyStimulus("lw_1c",  1'b0, 3'b010, 32'h1C, 32'h0, 2, 1'b0, 32'hDEADBEEF, 1, 0, 32'h0);

    // Rejected requests: no memory activity, error one cycle after accept.
    applyStimulus("err_lw_12",   1'b0, 3'b010, 32'h12,  32'h0, 1, 1'b1, 32'h0, 0, 0, 32'h0);
    applyStimulus("err_sh_03",   1'b1, 3'b001, 32'h03,  32'h5555, 1, 1'b1, 32'h0, 0, 0, 32'h0);
    applyStimulus("err_lw_100",  1'b0, 3'b010, 32'h100, 32'h0, 1, 1'b1, 32'h0, 0, 0, 32'h0);
    applyStimulus("err_st_f100", 1'b1, 3'b100, 32'h20,  32'h77, 1, 1'b1, 32'h0, 0, 0, 32'h0);
    applyStimulus("err_f011",    1'b0, 3'b011, 32'h20,  32'h0, 1, 1'b1, 32'h0, 0, 0, 32'h0);
    applyStimulus("lw_fc_last",  1'b0, 3'b010, 32'hFC,  32'h0, 2, 1'b0, 32'h0000003F, 1, 0, 32'h0);

    // Reset during RMW_RD of SB 0x08 must abort without a write or response.
    @(negedge clk);
    req_valid = 1'b1; req_store = 1'b1; req_funct3 = 3'b000;
    req_addr = 32'h08; req_wdata = 32'h000000FF;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    checkOutput("abort_in_rmw_rd", {31'h0, mem_re}, 32'h1);
    #1 rst_n = 1'b0;
    #1;
    checkOutput("abort_re_drop", {31'h0, mem_re}, 32'h0);
    we_n = 0; resp_n = 0;
    repeat (2) begin
      @(negedge clk);
      if (mem_we) we_n++;
      if (resp_valid) resp_n++;
    end
    rst_n = 1'b1;
    repeat (4) begin
      @(negedge clk);
      if (mem_we) we_n++;
      if (resp_valid) resp_n++;
    end
    checkOutput("abort_no_we", 32'(we_n), 32'h0);
    checkOutput("abort_no_resp", 32'(resp_n), 32'h0);
    checkOutput("abort_ready", {31'h0, req_ready}, 32'h1);
    checkOutput("abort_mem2", mem[2], 32'h00000002);
    checkOutput("no_re_we_overlap", 32'(overlap_cnt), 32'h0);

`ifdef LSU_STATS_EN
    // Counters restarted with the mid-run reset, so recount after it.
    exp_loads = 0; exp_stores = 0; exp_errs = 0;
    applyStimulus("st_lw0", 1'b0, 3'b010, 32'h00, 32'h0, 2, 1'b0, 32'h0, 1, 0, 32'h0);
    applyStimulus("st_lw1", 1'b0, 3'b010, 32'h04, 32'h0, 2, 1'b0, 32'h1, 1, 0, 32'h0);
    applyStimulus("st_lbu", 1'b0, 3'b100, 32'h0C, 32'h0, 2, 1'b0, 32'h3, 1, 0, 32'h0);
    applyStimulus("st_sw",  1'b1, 3'b010, 32'h30, 32'h0000CAFE, 2, 1'b0, 32'h0, 0, 1, 32'h0000CAFE);
    applyStimulus("st_sb",  1'b1, 3'b000, 32'h34, 32'h000000EE, 3, 1'b0, 32'h0, 1, 1, 32'h000000EE);
    applyStimulus("st_err", 1'b0, 3'b111, 32'h00, 32'h0, 1, 1'b1, 32'h0, 0, 0, 32'h0);
    checkOutput("stat_loads", {16'h0, stat_loads}, 32'(exp_loads));
    checkOutput("stat_stores", {16'h0, stat_stores}, 32'(exp_stores));
    checkOutput("stat_errs", {16'h0, stat_errs}, 32'(exp_errs));
`endif

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
